mem_access_ctrl: RTL and testbench

//   Memory-stage initiator for the pipelined Y86-64 core: decodes M_icode, drives a req/ack handshake

---
 rtl/mem_access_ctrl.sv | 106 ++++++++++
 tb/tb_mem_access_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: Y86-64 memory-stage initiator that stalls the pipeline while a
// req/ack access to a multi-cycle data memory is in flight; reports SADR on bad address or timeout.
module mem_access_ctrl #(
  parameter int ADDR_LIMIT = 512,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_valid,
  input  logic [3:0]  M_icode,
  input  logic [2:0]  M_stat,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic        m_stall,
  output logic        m_done
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd3;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d, err_q, err_d;
  logic [63:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, m_valM_q, m_valM_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          is_rd, is_wr, mem_ok, bad_addr, start, timeout;
  logic [63:0]   addr;

  assign is_rd    = M_icode inside {4'h5, 4'h9, 4'hB};
  assign is_wr    = M_icode inside {4'h4, 4'h8, 4'hA};
  assign addr     = (M_icode == 4'h9 || M_icode == 4'hB) ? M_valA : M_valE;
  assign mem_ok   = M_valid && (is_rd || is_wr) && M_stat == SAOK;
  assign bad_addr = addr >= 64'(ADDR_LIMIT);
  assign start    = mem_ok && !bad_addr && state_q == IDLE;
  assign timeout  = timer_q == TW'(TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m_valM_d    = m_valM_q;
    err_d       = err_q;
    timer_d     = timer_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = WAIT;
        mem_req_d   = 1'b1;
        mem_we_d    = is_wr;
        mem_addr_d  = addr;
        mem_wdata_d = M_valA;
        timer_d     = '0;
      end
      WAIT: if (mem_ack || timeout) begin
        state_d   = DONE;
        mem_req_d = 1'b0;
        err_d     = !mem_ack;
        m_valM_d  = (mem_ack && !mem_we_q) ? mem_rdata : m_valM_q;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m_valM_q    <= '0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m_valM_q    <= m_valM_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m_valM    = m_valM_q;
  assign m_stall   = rst_n && (start || state_q == WAIT);
  assign m_done    = rst_n && state_q == DONE;
  assign m_stat    = (rst_n && ((state_q == DONE && err_q) || (state_q == IDLE && mem_ok && bad_addr)))
                     ? SADR : M_stat;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: transaction-level random bench for mem_access_ctrl with a
// per-instruction reference model of latency, status and read-data results.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, M_valid, mem_ack;
  logic [3:0]  M_icode;
  logic [2:0]  M_stat;
  logic [63:0] M_valE, M_valA, mem_rdata;
  logic        mem_req, mem_we, m_stall, m_done;
  logic [63:0] mem_addr, mem_wdata, m_valM;
  logic [2:0]  m_stat;
  int          n_tests = 0, n_fail = 0;
  logic [63:0] exp_valM = '0, exp_addr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .M_valid(M_valid), .M_icode(M_icode), .M_stat(M_stat),
    .M_valE(M_valE), .M_valA(M_valA), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .m_valM(m_valM), .m_stat(m_stat), .m_stall(m_stall), .m_done(m_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One instruction held in M until the model says it retires; delay>=15 means no ack ever.
  task automatic run_txn(input logic v, input logic [3:0] ic, input logic [2:0] st,
                         input logic [63:0] ve, input logic [63:0] va, input int delay,
                         input logic [63:0] rdata);
    logic rd, wr, eligible, to;
    logic [63:0] a;
    int n;
    rd = ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
    wr = ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
    a  = (ic == 4'h9 || ic == 4'hB) ? va : ve;
    eligible = v && (rd || wr) && st == 3'd1;
    M_valid = v; M_icode = ic; M_stat = st; M_valE = ve; M_valA = va;
    mem_ack = 1'($urandom); mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    check("idle_req", mem_req, 0);
    check("idle_addr", mem_addr, exp_addr);
    if (!eligible || a >= 64'd512) begin
      check("nomem_stall", m_stall, 0);
      check("nomem_done", m_done, 0);
      check("nomem_stat", m_stat, eligible ? 3'd3 : st);
      check("nomem_valM", m_valM, exp_valM);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      return;
    end
    check("start_stall", m_stall, 1);
    check("start_stat", m_stat, st);
    to = delay >= 15;
    n = to ? 15 : delay + 1;
    exp_addr = a; exp_wdata = va; exp_we = wr;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      mem_ack = (k == delay);
      mem_rdata = (k == delay) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      check("wait_req", mem_req, 1);
      check("wait_we", mem_we, exp_we);
      check("wait_addr", mem_addr, exp_addr);
      check("wait_wdata", mem_wdata, exp_wdata);
      check("wait_stall", m_stall, 1);
      check("wait_done", m_done, 0);
      @(posedge clk); #1;
    end
    if (rd && !to) exp_valM = rdata;
    mem_ack = 1'($urandom); mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    check("done_pulse", m_done, 1);
    check("done_stall", m_stall, 0);
    check("done_req", mem_req, 0);
    check("done_stat", m_stat, to ? 3'd3 : 3'd1);
    check("done_valM", m_valM, exp_valM);
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; M_valid = 1'b1; M_icode = 4'h5; M_stat = 3'd2; M_valE = 64'h10; M_valA = 0;
    mem_ack = 1'b0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_stall", m_stall, 0);
    check("rst_done", m_done, 0);
    check("rst_stat", m_stat, 3'd2);
    check("rst_valM", m_valM, 0);
    check("rst_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(1, 4'h5, 3'd1, 64'h10, 64'h0, 0, 64'hDEAD);
    run_txn(1, 4'h4, 3'd1, 64'h20, 64'h55, 3, 64'h1234);
    check("wr_keeps_valM", m_valM, 64'hDEAD);
    run_txn(1, 4'hB, 3'd1, 64'h0, 64'h600, 0, 64'h0);
    run_txn(1, 4'h8, 3'd1, 64'h30, 64'h77, 99, 64'h0);
    run_txn(1, 4'h9, 3'd1, 64'h0, 64'h1F8, 14, 64'hBEEF);
    run_txn(1, 4'h5, 3'd1, 64'h1FF, 64'h0, 1, 64'hCAFE);
    run_txn(1, 4'h5, 3'd1, 64'h200, 64'h0, 1, 64'h0);
    for (int i = 0; i < 250; i++) begin
      logic [63:0] ve, va;
      logic [2:0] st;
      ve = ($urandom % 5 == 0) ? {$urandom, $urandom} : 64'($urandom % 600);
      va = ($urandom % 5 == 0) ? {$urandom, $urandom} : 64'($urandom % 600);
      st = ($urandom % 4 == 0) ? 3'($urandom) : 3'd1;
      run_txn(($urandom % 10) != 0, 4'($urandom), st, ve, va, int'($urandom % 18), {$urandom, $urandom});
    end
    // Reset while an access is outstanding: the access is dropped, not retried.
    M_valid = 1'b1; M_icode = 4'h5; M_stat = 3'd1; M_valE = 64'h40; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstw_stall", m_stall, 0);
    check("rstw_stat", m_stat, 3'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; M_icode = 4'h6; M_stat = 3'd2; mem_ack = 1'b1;
    exp_valM = '0; exp_addr = '0;
    @(negedge clk);
    check("rstw_req", mem_req, 0);
    check("rstw_valM", m_valM, 0);
    check("rstw_stat2", m_stat, 3'd2);
    check("rstw_nostall", m_stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_ack_ignored", mem_req, 0);
    check("rstw_nodone", m_done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
